coin_acceptor: RTL

Front-end stage that converts the two raw coin-sensor lines of the vending front panel into the 2-bit coin code consumed by `vending_machine`. It synchronises and debounces each sensor, rejects ambiguous or overflowing inserts, buffers accepted coins in a small FIFO, and paces them out as single-cycle codes. Its `coin_out` drives the `in` port of `vending_machine` directly.

---
 rtl/vm_pkg.sv | 25 ++
 rtl/coin_acceptor_if.sv | 35 +++
 rtl/coin_debounce.sv | 57 +++++
 rtl/coin_acceptor.sv | 130 +++++++++++++
 4 files changed

// File: rtl/vm_pkg.sv
// Shared definitions for the vending front end (coin_acceptor, vending_machine).
//   coin_t      : 2-bit coin code carried on coin_out / vending_machine.in
//   COIN_*      : coin code constants (11 is never driven)
//   out_state_t : coin_acceptor output FSM states
//   DB_CNT_W    : width of the debounce counters (DEBOUNCE <= 15)
//   GAP_CNT_W   : width of the inter-code gap counter (GAP <= 7)
package vm_pkg;

   typedef logic [1:0] coin_t;

   localparam coin_t COIN_NONE = 2'b00;
   localparam coin_t COIN_5    = 2'b01;
   localparam coin_t COIN_10   = 2'b10;

   localparam int unsigned DB_CNT_W  = 4;
   localparam int unsigned GAP_CNT_W = 3;

   // ST_ prefix keeps the GAP state distinct from the GAP parameter
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EMIT,
      ST_GAP
   } out_state_t;

endpackage

// File: rtl/coin_acceptor_if.sv
// Coin front-panel bus between the sensor side and the coin acceptor.
//   coin5_raw  : raw 5-unit sensor, asynchronous to clk
//   coin10_raw : raw 10-unit sensor, asynchronous to clk
//   coin_out   : coin code to vending_machine.in (single-cycle pulses)
//   reject     : one-cycle pulse, coin sent to the return chute
//   pending    : coin FIFO occupancy
// master drives the sensors and observes results; slave is the acceptor.
interface coin_acceptor_if #(
   parameter int unsigned DEPTH = 4
);
   import vm_pkg::*;

   logic                   coin5_raw;
   logic                   coin10_raw;
   coin_t                  coin_out;
   logic                   reject;
   logic [$clog2(DEPTH):0] pending;

   modport master (
      output coin5_raw,
      output coin10_raw,
      input  coin_out,
      input  reject,
      input  pending
   );

   modport slave (
      input  coin5_raw,
      input  coin10_raw,
      output coin_out,
      output reject,
      output pending
   );

endinterface

// File: rtl/coin_debounce.sv
// One coin-sensor channel: 2-flop synchroniser, high/low run counters and
// arm logic. A coin qualifies once per insertion.
//   clk, rst : system clock, asynchronous active-high reset
//   raw      : raw sensor line, asynchronous to clk
//   qualify  : 1-cycle pulse; the coin is taken on the edge that ends it
module coin_debounce
   import vm_pkg::*;
#(
   parameter int unsigned DEBOUNCE = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic qualify
);

   localparam logic [DB_CNT_W-1:0] LIMIT    = DB_CNT_W'(DEBOUNCE);
   localparam logic [DB_CNT_W-1:0] LIMIT_M1 = DB_CNT_W'(DEBOUNCE - 1);

   logic                sync1;
   logic                sync2;
   logic [DB_CNT_W-1:0] high_cnt;
   logic [DB_CNT_W-1:0] low_cnt;
   logic                armed;

   // Asserted in the cycle whose closing edge brings high_cnt to DEBOUNCE,
   // so the consumer captures the coin on that same edge.
   assign qualify = armed && sync2 && (high_cnt == LIMIT_M1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1    <= 1'b0;
         sync2    <= 1'b0;
         high_cnt <= '0;
         low_cnt  <= '0;
         armed    <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;

         // Both counters saturate so a line stuck either way cannot wrap
         if (sync2) begin
            low_cnt <= '0;
            if (high_cnt != LIMIT) high_cnt <= high_cnt + 1'b1;
         end else begin
            high_cnt <= '0;
            if (low_cnt != LIMIT) low_cnt <= low_cnt + 1'b1;
         end

         if (qualify)
            armed <= 1'b0;
         else if (!sync2 && (low_cnt == LIMIT_M1))
            armed <= 1'b1;
      end
   end

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor: debounces both sensors, rejects ambiguous or overflowing
// inserts, queues accepted coins and paces them out as 1-cycle codes.
//   clk, rst : system clock, asynchronous active-high reset
//   bus      : coin_acceptor_if.slave (raw sensors in; coin_out, reject,
//              pending out)
module coin_acceptor
   import vm_pkg::*;
#(
   parameter int unsigned DEBOUNCE = 4,
   parameter int unsigned GAP      = 2,
   parameter int unsigned DEPTH    = 4
) (
   input  logic            clk,
   input  logic            rst,
   coin_acceptor_if.slave  bus
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;
   localparam logic [PW-1:0]        FULL_CNT = PW'(DEPTH);
   localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'(GAP - 1);

   logic qual5;
   logic qual10;

   coin_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb5 (
      .clk     (clk),
      .rst     (rst),
      .raw     (bus.coin5_raw),
      .qualify (qual5)
   );

   coin_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb10 (
      .clk     (clk),
      .rst     (rst),
      .raw     (bus.coin10_raw),
      .qualify (qual10)
   );

   // FIFO storage; DEPTH is a power of two so pointers wrap on their own
   coin_t         mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [PW-1:0] count;

   out_state_t           state;
   out_state_t           state_next;
   logic [GAP_CNT_W-1:0] gap_cnt;
   coin_t                code_next;
   coin_t                coin_out_q;
   logic                 reject_q;
   logic                 pop;

   logic  single;
   logic  full;
   logic  push;
   logic  reject_next;
   coin_t in_code;

   assign single  = qual5 ^ qual10;
   assign full    = (count == FULL_CNT);
   assign in_code = qual5 ? COIN_5 : COIN_10;
   // A same-edge pop frees the slot, so a full FIFO still takes the coin
   assign push        = single && (!full || pop);
   assign reject_next = (qual5 && qual10) || (single && full && !pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= COIN_NONE;
      end else begin
         if (push) begin
            mem[wr_ptr] <= in_code;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Output FSM: state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   // Output FSM: next state
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (count != '0) state_next = ST_EMIT;
         ST_EMIT: state_next = ST_GAP;
         ST_GAP:  if (gap_cnt == GAP_LAST) state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // Output FSM: outputs (pop strobe and the code to register onto coin_out)
   always_comb begin
      pop       = 1'b0;
      code_next = COIN_NONE;
      if ((state == ST_IDLE) && (count != '0)) begin
         pop       = 1'b1;
         code_next = mem[rd_ptr];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gap_cnt    <= '0;
         coin_out_q <= COIN_NONE;
         reject_q   <= 1'b0;
      end else begin
         gap_cnt    <= (state == ST_GAP) ? gap_cnt + 1'b1 : '0;
         coin_out_q <= code_next;
         reject_q   <= reject_next;
      end
   end

   assign bus.coin_out = coin_out_q;
   assign bus.reject   = reject_q;
   assign bus.pending  = count;

endmodule
